// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled spi_clk/csb/mosi, one-entry transmit buffer, valid-pulse receive.
// Ports: clk, rst (async high); spi_clk/spi_csb/spi_mosi in; spi_miso/spi_miso_oe out;
//   tx_data/tx_valid/tx_ready buffer handshake; rx_data/rx_valid receive;
//   tx_underrun pulse; busy.
// Optional: define SPI_TARGET_ECHO_EN so that an underrun reloads the last received word.
module spi_target #(
  parameter int                 DATA_W      = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  FILL        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_csb,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   csb_d;

  logic sclk_s;
  logic csb_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic csb_fall;
  logic csb_rise;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_base;
  logic              word_done;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_buf;
  logic              buf_full;
  logic              accept;
  logic              do_load;
  logic [DATA_W-1:0] under_word;
  logic [DATA_W-1:0] load_word;

  // csb history resets low, so a csb already low at reset release
  // cannot produce a falling edge until it has been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      csb_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      csb_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      csb_d     <= csb_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign csb_fall  = csb_d & ~csb_s;
  assign csb_rise  = ~csb_d & csb_s;

`ifdef SPI_TARGET_ECHO_EN
  assign under_word = rx_data;
`else
  assign under_word = FILL;
`endif

  assign accept    = tx_valid & ~buf_full;
  assign load_word = buf_full ? tx_buf : under_word;
  assign cnt_base  = (cnt == CNT_FULL) ? '0 : cnt;
  assign tx_ready  = ~buf_full;
  assign busy      = (state == ACTIVE);

  // A load uses the buffer as it stood before this cycle; a word
  // accepted in the same cycle waits for the next load.
  always_comb begin
    do_load = 1'b0;
    unique case (state)
      IDLE:   do_load = csb_fall;
      ACTIVE: do_load = ~csb_rise & sclk_fall & word_done;
      default: do_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word_done   <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= do_load & ~buf_full;
      if (do_load && buf_full) begin
        buf_full <= 1'b0;
      end
      if (accept) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          cnt         <= '0;
          word_done   <= 1'b0;
          spi_miso    <= 1'b0;
          spi_miso_oe <= 1'b0;
          if (csb_fall) begin
            tx_shift    <= load_word;
            spi_miso    <= load_word[DATA_W-1];
            spi_miso_oe <= 1'b1;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cnt == CNT_FULL) begin
            rx_data   <= rx_shift;
            rx_valid  <= 1'b1;
            word_done <= 1'b1;
          end
          if (csb_rise) begin
            state       <= IDLE;
            cnt         <= '0;
            word_done   <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
          end else begin
            cnt <= sclk_rise ? cnt_base + CW'(1) : cnt_base;
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            end
            if (sclk_fall) begin
              if (word_done) begin
                tx_shift  <= load_word;
                spi_miso  <= load_word[DATA_W-1];
                word_done <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                spi_miso <= tx_shift[DATA_W-2];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: vector table, corner sequences,
// and random frames against a queue-based transfer model.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_csb;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  spi_target dut (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_csb     (spi_csb),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         nchecks = 0;
  int         nerr = 0;
  int         under_cnt = 0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_underrun) under_cnt++;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    spi_clk  = 1'b0;
    spi_csb  = 1'b1;
    spi_mosi = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(4);
    rxq.delete();
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    spi_clk = 1'b0;
  endtask

  // spi_clk = clk/8: mosi and the falling edge together, miso sampled
  // just before the rising edge.
  task automatic xfer(input logic [7:0] m, input logic mid_v,
                      input logic [7:0] mid_d, output logic [7:0] s);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = m[i];
      if (mid_v && i == 4) begin
        write_tx(mid_d);
        tick(3);
      end else begin
        tick(4);
      end
      s[i] = spi_miso;
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
  endtask

  task automatic csb_low();
    spi_csb = 1'b0;
    tick(6);
  endtask

  task automatic csb_high();
    tick(4);
    spi_csb = 1'b1;
    tick(6);
  endtask

  typedef struct {
    int             n;
    logic [2:0][7:0] mosi;
    logic           pre_v;
    logic [7:0]     pre_d;
    logic           mid_v;
    logic [7:0]     mid_d;
    logic [2:0][7:0] miso;
    int             under;
  } vec_t;

  function automatic vec_t mk(
    input int n,
    input logic [7:0] m0, input logic [7:0] m1,
    input logic pv, input logic [7:0] pd,
    input logic mv, input logic [7:0] md,
    input logic [7:0] e0, input logic [7:0] e1,
    input int u);
    vec_t v;
    v.n     = n;
    v.mosi  = {8'h00, m1, m0};
    v.pre_v = pv;
    v.pre_d = pd;
    v.mid_v = mv;
    v.mid_d = md;
    v.miso  = {8'h00, e1, e0};
    v.under = u;
    return v;
  endfunction

  vec_t       vt[5];
  logic [7:0] s;
  logic [7:0] got[3];
  int         u0;
  int         rx_n0;

  // model state for random frames
  logic [7:0] mbuf[$];
  logic [7:0] last_rx;
  logic [7:0] exp_miso[4];
  int         exp_under;

  function automatic logic [7:0] fill_word();
`ifdef SPI_TARGET_ECHO_EN
    return last_rx;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] model_load();
    if (mbuf.size() != 0) return mbuf.pop_front();
    exp_under++;
    return fill_word();
  endfunction

  initial begin
    vt[0] = mk(1, 8'hA5, 8'h00, 0, 8'h00, 0, 8'h00,
               8'h00, 8'h00, 2);
    vt[1] = mk(1, 8'h5A, 8'h00, 1, 8'h3C, 0, 8'h00,
               8'h3C, 8'h00, 1);
    vt[2] = mk(2, 8'h12, 8'h34, 0, 8'h00, 1, 8'h56,
               8'h00, 8'h56, 2);
    vt[3] = mk(2, 8'h81, 8'h7E, 1, 8'h99, 1, 8'h42,
               8'h99, 8'h42, 1);
    vt[4] = mk(1, 8'hFF, 8'h00, 1, 8'h00, 0, 8'h00,
               8'h00, 8'h00, 1);

    do_reset();
    chk("rst_miso", {31'd0, spi_miso}, 0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 1);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_underrun", {31'd0, tx_underrun}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      u0 = under_cnt;
      if (vt[v].pre_v) write_tx(vt[v].pre_d);
      csb_low();
      for (int k = 0; k < vt[v].n; k++) begin
        xfer(vt[v].mosi[k], vt[v].mid_v && k == 0,
             vt[v].mid_d, s);
        chk($sformatf("vec%0d_miso%0d", v, k),
            {24'd0, s}, {24'd0, vt[v].miso[k]});
      end
      csb_high();
      chk($sformatf("vec%0d_rx_count", v),
          rxq.size(), vt[v].n);
      for (int k = 0; k < vt[v].n && k < rxq.size(); k++)
        chk($sformatf("vec%0d_rx%0d", v, k),
            {24'd0, rxq[k]}, {24'd0, vt[v].mosi[k]});
      chk($sformatf("vec%0d_underruns", v),
          under_cnt - u0, vt[v].under);
    end

    // buffered word: ready drops on accept, returns at csb fall
    do_reset();
    write_tx(8'h3C);
    chk("buf_ready_full", {31'd0, tx_ready}, 0);
    csb_low();
    chk("buf_ready_load", {31'd0, tx_ready}, 1);
    chk("buf_busy", {31'd0, busy}, 1);
    chk("buf_oe", {31'd0, spi_miso_oe}, 1);
    xfer(8'h11, 1'b0, 8'h00, s);
    chk("buf_miso", {24'd0, s}, 32'h3C);
    csb_high();
    chk("buf_oe_off", {31'd0, spi_miso_oe}, 0);

    // abort after 5 bits, then a clean frame
    do_reset();
    csb_low();
    repeat (5) spi_bit(1'b1);
    csb_high();
    chk("abort_no_rx", rxq.size(), 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_oe", {31'd0, spi_miso_oe}, 0);
    csb_low();
    xfer(8'h81, 1'b0, 8'h00, s);
    csb_high();
    chk("abort_next_count", rxq.size(), 1);
    if (rxq.size() > 0)
      chk("abort_next_rx", {24'd0, rxq[0]}, 32'h81);

    // reset mid-word with csb held low
    do_reset();
    write_tx(8'hE7);
    csb_low();
    repeat (3) spi_bit(1'b1);
    #2 rst = 1'b1;
    #2;
    chk("mrst_oe", {31'd0, spi_miso_oe}, 0);
    chk("mrst_miso", {31'd0, spi_miso}, 0);
    chk("mrst_ready", {31'd0, tx_ready}, 1);
    chk("mrst_busy", {31'd0, busy}, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    rxq.delete();
    xfer(8'hA5, 1'b0, 8'h00, s);
    xfer(8'h5A, 1'b0, 8'h00, s);
    tick(4);
    chk("mrst_no_rx", rxq.size(), 0);
    chk("mrst_idle", {31'd0, busy}, 0);
    chk("mrst_rx_data", {24'd0, rx_data}, 0);
    spi_csb = 1'b1;
    tick(6);
    csb_low();
    chk("mrst_active", {31'd0, busy}, 1);
    xfer(8'hC3, 1'b0, 8'h00, s);
    csb_high();
    chk("mrst_rx_count", rxq.size(), 1);
    if (rxq.size() > 0)
      chk("mrst_rx", {24'd0, rxq[0]}, 32'hC3);

    // echo / fill on an empty buffer in the following frame
    do_reset();
    csb_low();
    xfer(8'h5A, 1'b0, 8'h00, s);
    csb_high();
    csb_low();
    xfer(8'h00, 1'b0, 8'h00, s);
    csb_high();
`ifdef SPI_TARGET_ECHO_EN
    chk("echo_miso", {24'd0, s}, 32'h5A);
`else
    chk("echo_miso", {24'd0, s}, 32'h00);
`endif

    // random frames against the transfer model
    do_reset();
    mbuf.delete();
    last_rx = 8'h00;
    for (int f = 0; f < 40; f++) begin
      int         n;
      logic       pv;
      logic       mv;
      logic [7:0] pd;
      logic [7:0] md;
      logic [7:0] m[3];
      n  = $urandom_range(1, 3);
      pv = 1'($urandom_range(0, 1));
      mv = 1'($urandom_range(0, 1));
      pd = 8'($urandom);
      md = 8'($urandom);
      for (int k = 0; k < 3; k++) m[k] = 8'($urandom);
      rxq.delete();
      u0 = under_cnt;
      exp_under = 0;
      if (pv) begin
        chk($sformatf("rnd%0d_ready", f), {31'd0, tx_ready},
            {31'd0, mbuf.size() == 0});
        write_tx(pd);
        if (mbuf.size() == 0) mbuf.push_back(pd);
      end
      csb_low();
      exp_miso[0] = model_load();
      for (int k = 0; k < n; k++) begin
        xfer(m[k], mv && k == 0, md, got[k]);
        if (mv && k == 0 && mbuf.size() == 0) mbuf.push_back(md);
        last_rx = m[k];
        exp_miso[k+1] = model_load();
        chk($sformatf("rnd%0d_miso%0d", f, k),
            {24'd0, got[k]}, {24'd0, exp_miso[k]});
      end
      csb_high();
      chk($sformatf("rnd%0d_rx_count", f), rxq.size(), n);
      for (int k = 0; k < n && k < rxq.size(); k++)
        chk($sformatf("rnd%0d_rx%0d", f, k),
            {24'd0, rxq[k]}, {24'd0, m[k]});
      chk($sformatf("rnd%0d_underruns", f),
          under_cnt - u0, exp_under);
      chk($sformatf("rnd%0d_ready_end", f), {31'd0, tx_ready},
          {31'd0, mbuf.size() == 0});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
